// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage MIPS core: opcodes, ALU op classes and
// the decoded control bundle carried from ID into EX.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [1:0] ALUOP_RTYPE = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_SLT   = 2'b10;
  localparam logic [1:0] ALUOP_ADD   = 2'b11;

  typedef struct packed {
    logic       regdst;
    logic       jump;
    logic       branch;
    logic       memread;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic [1:0] aluop;
  } ctrl_t;

  // An all-zero bundle performs no register, memory or PC write.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection between the load sitting in EX and the
// instruction being decoded in ID. Purely combinational.
module hazard_detect
  import cpu_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic            i_ex_memread,
  input  logic [RA_W-1:0] i_ex_rt,
  input  logic [RA_W-1:0] i_id_rs,
  input  logic [RA_W-1:0] i_id_rt,
  input  logic            i_id_regdst,
  input  logic            i_id_branch,
  input  logic            i_id_memwrite,
  input  logic            i_flush,
  output logic            o_load_use,
  output logic            o_hold
);

  logic w_uses_rt;

  // R-type, beq and sw read rt as a source; loads and immediates do not.
  assign w_uses_rt  = i_id_regdst | i_id_branch | i_id_memwrite;
  assign o_load_use = i_ex_memread & (i_ex_rt != '0) &
                      ((i_ex_rt == i_id_rs) | (w_uses_rt & (i_ex_rt == i_id_rt)));
  // A flushed ID instruction is being discarded, so there is nothing to hold.
  assign o_hold     = o_load_use & ~i_flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, EX-resolved flush
// and saturating stall/flush event counters.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_regdst,
  input  logic              id_jump,
  input  logic              id_branch,
  input  logic              id_memread,
  input  logic              id_memtoreg,
  input  logic              id_memwrite,
  input  logic              id_alusrc,
  input  logic              id_regwrite,
  input  logic [1:0]        id_aluop,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm_ext,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic [RA_W-1:0]   id_rd,
  input  logic              flush,
  output logic              ex_regdst,
  output logic              ex_jump,
  output logic              ex_branch,
  output logic              ex_memread,
  output logic              ex_memtoreg,
  output logic              ex_memwrite,
  output logic              ex_alusrc,
  output logic              ex_regwrite,
  output logic [1:0]        ex_aluop,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm_ext,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [RA_W-1:0]   ex_rs,
  output logic [RA_W-1:0]   ex_rt,
  output logic [RA_W-1:0]   ex_rd,
  output logic              hold_pc,
  output logic              hold_ifid,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  ctrl_t             r_ctrl;
  ctrl_t             w_id_ctrl;
  logic [DATA_W-1:0] r_rs_data, r_rt_data, r_imm_ext, r_pc4;
  logic [RA_W-1:0]   r_rs, r_rt, r_rd;
  logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;
  logic              w_load_use;
  logic              w_hold;

  assign w_id_ctrl = '{regdst: id_regdst, jump: id_jump, branch: id_branch,
                       memread: id_memread, memtoreg: id_memtoreg,
                       memwrite: id_memwrite, alusrc: id_alusrc,
                       regwrite: id_regwrite, aluop: id_aluop};

  hazard_detect #(.RA_W(RA_W)) u_hazard (
    .i_ex_memread  (r_ctrl.memread),
    .i_ex_rt       (r_rt),
    .i_id_rs       (id_rs),
    .i_id_rt       (id_rt),
    .i_id_regdst   (id_regdst),
    .i_id_branch   (id_branch),
    .i_id_memwrite (id_memwrite),
    .i_flush       (flush),
    .o_load_use    (w_load_use),
    .o_hold        (w_hold)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl      <= CTRL_BUBBLE;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm_ext   <= '0;
      r_pc4       <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (flush) begin
      r_ctrl    <= CTRL_BUBBLE;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm_ext <= '0;
      r_pc4     <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end else begin
      // On a stall the operands still load; the bubble control makes them inert.
      r_ctrl    <= w_load_use ? CTRL_BUBBLE : w_id_ctrl;
      r_rs_data <= id_rs_data;
      r_rt_data <= id_rt_data;
      r_imm_ext <= id_imm_ext;
      r_pc4     <= id_pc4;
      r_rs      <= id_rs;
      r_rt      <= id_rt;
      r_rd      <= id_rd;
      if (w_load_use && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign ex_regdst   = r_ctrl.regdst;
  assign ex_jump     = r_ctrl.jump;
  assign ex_branch   = r_ctrl.branch;
  assign ex_memread  = r_ctrl.memread;
  assign ex_memtoreg = r_ctrl.memtoreg;
  assign ex_memwrite = r_ctrl.memwrite;
  assign ex_alusrc   = r_ctrl.alusrc;
  assign ex_regwrite = r_ctrl.regwrite;
  assign ex_aluop    = r_ctrl.aluop;
  assign ex_rs_data  = r_rs_data;
  assign ex_rt_data  = r_rt_data;
  assign ex_imm_ext  = r_imm_ext;
  assign ex_pc4      = r_pc4;
  assign ex_rs       = r_rs;
  assign ex_rt       = r_rt;
  assign ex_rd       = r_rd;
  assign hold_pc     = w_hold;
  assign hold_ifid   = w_hold;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, capture, load-use
// stall, false-stall cases, flush priority, async reset mid-stall, saturation.
module tb_id_ex_stage;
  import cpu_pkg::*;

  logic        clk, rst_n;
  logic        id_regdst, id_jump, id_branch, id_memread, id_memtoreg;
  logic        id_memwrite, id_alusrc, id_regwrite;
  logic [1:0]  id_aluop;
  logic [31:0] id_rs_data, id_rt_data, id_imm_ext, id_pc4;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        flush;
  logic        ex_regdst, ex_jump, ex_branch, ex_memread, ex_memtoreg;
  logic        ex_memwrite, ex_alusrc, ex_regwrite;
  logic [1:0]  ex_aluop;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm_ext, ex_pc4;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        hold_pc, hold_ifid;
  logic [15:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_regdst(id_regdst), .id_jump(id_jump), .id_branch(id_branch),
    .id_memread(id_memread), .id_memtoreg(id_memtoreg), .id_memwrite(id_memwrite),
    .id_alusrc(id_alusrc), .id_regwrite(id_regwrite), .id_aluop(id_aluop),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm_ext(id_imm_ext),
    .id_pc4(id_pc4), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
    .ex_regdst(ex_regdst), .ex_jump(ex_jump), .ex_branch(ex_branch),
    .ex_memread(ex_memread), .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite),
    .ex_alusrc(ex_alusrc), .ex_regwrite(ex_regwrite), .ex_aluop(ex_aluop),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm_ext(ex_imm_ext),
    .ex_pc4(ex_pc4), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .hold_pc(hold_pc), .hold_ifid(hold_ifid),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_id();
    {id_regdst, id_jump, id_branch, id_memread, id_memtoreg} = '0;
    {id_memwrite, id_alusrc, id_regwrite} = '0;
    id_aluop = 2'b00;
    id_rs_data = '0; id_rt_data = '0; id_imm_ext = '0; id_pc4 = '0;
    id_rs = '0; id_rt = '0; id_rd = '0;
  endtask

  task automatic set_lw(input logic [4:0] rs, input logic [4:0] rt);
    clear_id();
    id_memread = 1; id_memtoreg = 1; id_regwrite = 1; id_alusrc = 1;
    id_aluop = ALUOP_ADD; id_rs = rs; id_rt = rt; id_imm_ext = 32'h10;
  endtask

  task automatic set_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    clear_id();
    id_regdst = 1; id_regwrite = 1; id_aluop = ALUOP_RTYPE;
    id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = 32'h1111; id_rt_data = 32'h2222; id_pc4 = 32'h40;
  endtask

  task automatic set_addi(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] imm);
    clear_id();
    id_regwrite = 1; id_alusrc = 1; id_aluop = ALUOP_ADD;
    id_rs = rs; id_rt = rt; id_imm_ext = imm;
  endtask

  task automatic edge_then_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    clear_id();
    // Reset with random ID-side inputs and clock running
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      {id_regdst, id_jump, id_branch, id_memread, id_memtoreg} = 5'($urandom);
      {id_memwrite, id_alusrc, id_regwrite} = 3'($urandom);
      id_aluop = 2'($urandom);
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm_ext = $urandom; id_pc4 = $urandom;
      id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
    end
    #1;
    chk("rst_regwrite", 32'(ex_regwrite), 32'd0);
    chk("rst_memread", 32'(ex_memread), 32'd0);
    chk("rst_aluop", 32'(ex_aluop), 32'd0);
    chk("rst_rs_data", ex_rs_data, 32'd0);
    chk("rst_pc4", ex_pc4, 32'd0);
    chk("rst_rt", 32'(ex_rt), 32'd0);
    chk("rst_hold_pc", 32'(hold_pc), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);

    // Release and capture an addi
    @(negedge clk);
    rst_n = 1'b1;
    set_addi(5'd1, 5'd4, 32'd5);
    edge_then_sample();
    chk("addi_regwrite", 32'(ex_regwrite), 32'd1);
    chk("addi_alusrc", 32'(ex_alusrc), 32'd1);
    chk("addi_aluop", 32'(ex_aluop), 32'b11);
    chk("addi_imm", ex_imm_ext, 32'd5);
    chk("addi_rs", 32'(ex_rs), 32'd1);

    // Load-use: lw $2 then add rs=2 rt=3
    @(negedge clk);
    set_lw(5'd1, 5'd2);
    edge_then_sample();
    chk("lw_memread", 32'(ex_memread), 32'd1);
    @(negedge clk);
    set_add(5'd2, 5'd3, 5'd4);
    #1;
    chk("lu_hold_pc", 32'(hold_pc), 32'd1);
    chk("lu_hold_ifid", 32'(hold_ifid), 32'd1);
    edge_then_sample();
    chk("bub_regwrite", 32'(ex_regwrite), 32'd0);
    chk("bub_memread", 32'(ex_memread), 32'd0);
    chk("bub_regdst", 32'(ex_regdst), 32'd0);
    chk("bub_rs_captured", 32'(ex_rs), 32'd2);
    chk("bub_stall_cnt", 32'(stall_cnt), 32'd1);
    chk("bub_hold_clear", 32'(hold_pc), 32'd0);
    edge_then_sample();
    chk("add_regwrite", 32'(ex_regwrite), 32'd1);
    chk("add_regdst", 32'(ex_regdst), 32'd1);
    chk("add_rd", 32'(ex_rd), 32'd4);
    chk("add_rt_data", ex_rt_data, 32'h2222);
    chk("add_stall_cnt", 32'(stall_cnt), 32'd1);

    // lw rt=0 followed by R-type rs=0: no stall
    @(negedge clk);
    set_lw(5'd1, 5'd0);
    edge_then_sample();
    @(negedge clk);
    set_add(5'd0, 5'd0, 5'd6);
    #1;
    chk("rt0_no_hold", 32'(hold_pc), 32'd0);

    // lw rt=5 then addi rs=7 rt=5: rt not a source
    @(negedge clk);
    set_lw(5'd1, 5'd5);
    edge_then_sample();
    @(negedge clk);
    set_addi(5'd7, 5'd5, 32'd9);
    #1;
    chk("addi_no_hold", 32'(hold_ifid), 32'd0);
    // sw rs=7 rt=5 reads rt: stall requested
    clear_id();
    id_memwrite = 1; id_alusrc = 1; id_aluop = ALUOP_ADD; id_rs = 5'd7; id_rt = 5'd5;
    id_rs_data = 32'hABCD;
    #1;
    chk("sw_hold", 32'(hold_pc), 32'd1);
    // Flush wins over load-use
    flush = 1'b1;
    #1;
    chk("flush_no_hold_pc", 32'(hold_pc), 32'd0);
    chk("flush_no_hold_ifid", 32'(hold_ifid), 32'd0);
    edge_then_sample();
    chk("flush_memwrite", 32'(ex_memwrite), 32'd0);
    chk("flush_memread", 32'(ex_memread), 32'd0);
    chk("flush_rs_data", ex_rs_data, 32'd0);
    chk("flush_rt", 32'(ex_rt), 32'd0);
    chk("flush_cnt_1", 32'(flush_cnt), 32'd1);
    chk("flush_stall_cnt", 32'(stall_cnt), 32'd1);

    // Async reset mid-stall
    @(negedge clk);
    flush = 1'b0;
    set_lw(5'd1, 5'd6);
    edge_then_sample();
    @(negedge clk);
    set_add(5'd6, 5'd1, 5'd8);
    #1;
    chk("ar_hold_before", 32'(hold_pc), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_memread", 32'(ex_memread), 32'd0);
    chk("ar_regwrite", 32'(ex_regwrite), 32'd0);
    chk("ar_hold", 32'(hold_pc), 32'd0);
    chk("ar_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("ar_flush_cnt", 32'(flush_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    edge_then_sample();
    chk("ar_post_regwrite", 32'(ex_regwrite), 32'd1);
    chk("ar_post_rs", 32'(ex_rs), 32'd6);
    chk("ar_post_stall_cnt", 32'(stall_cnt), 32'd0);

    // Flush counter saturation
    @(negedge clk);
    flush = 1'b1;
    repeat (3) edge_then_sample();
    chk("sat_cnt_3", 32'(flush_cnt), 32'd3);
    repeat (65532) @(posedge clk);
    #1;
    chk("sat_cnt_ffff", 32'(flush_cnt), 32'hFFFF);
    repeat (5) @(posedge clk);
    #1;
    chk("sat_cnt_hold", 32'(flush_cnt), 32'hFFFF);
    chk("sat_stall_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    flush = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
